pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and pipeline sequencing controller for the 5-stage rv32i core. It watches register usage in ID, ID/EX and EX/MEM, plus the branch/jump redirect resolved in ID and the data-memory busy signal. From these it generates the stall, flush and freeze controls for the PC register, the IF/ID stage register and the ID/EX stage register. It also keeps free-running stall and flush statistics counters. It is the single source of the `stall`/`flush` inputs of the IF/ID stage register.

## Interface
- `REG_ADDR_W`, 5, register-file address width
- `STAT_W`, 32, width of statistics counters
- `clk`  in  1  core clock
- `rst`  in  1  synchronous reset, active-high
- `id_rs1_addr`, `id_rs2_addr`  in  REG_ADDR_W  source registers of the instruction in ID
- `id_rs1_used`, `id_rs2_used`  in  1  instruction in ID reads rs1/rs2
- `id_is_branch`  in  1  instruction in ID is BRANCH or JALR, so it needs its operands in ID
- `id_redirect`  in  1  ID resolved a taken branch, JAL or JALR this cycle
- `idex_rd_addr`  in  REG_ADDR_W  destination register of the instruction in ID/EX
- `idex_reg_write`, `idex_mem_read`  in  1  ID/EX instruction writes rd / is a LOAD
- `exmem_rd_addr`  in  REG_ADDR_W  destination register of the instruction in EX/MEM
- `exmem_mem_read`  in  1  EX/MEM instruction is a LOAD
- `dmem_busy`  in  1  data memory not ready; the whole pipeline must hold
- `pc_stall`  out  1  PC holds its value
- `ifid_stall`  out  1  IF/ID holds (`STALL_EN`)
- `ifid_flush`  out  1  IF/ID loads NOP (`FLUSH_EN`)
- `idex_flush`  out  1  ID/EX loads a bubble
- `pipe_freeze`  out  1  ID/EX, EX/MEM and MEM/WB hold
- `stall_cycles`  out  STAT_W  count of cycles with `ifid_stall`=1
- `flush_count`  out  STAT_W  count of cycles with `ifid_flush`=1

## Operation
- A register match requires the address to be equal, the matching `*_used` bit to be set, and rd≠x0.
- Hazard classes are evaluated combinationally in state RUN. Each gives a bubble count N:
  - Load-use: a match with ID/EX rd while `idex_mem_read`=1. N=1, or N=2 if `id_is_branch`=1.
  - Branch-after-ALU: `id_is_branch`=1 and a match with ID/EX rd while `idex_reg_write`=1 and `idex_mem_read`=0. N=1.
  - Branch-after-load in MEM: `id_is_branch`=1 and a match with EX/MEM rd while `exmem_mem_read`=1. N=1.
  - If several classes hit, the largest N wins.
- The FSM has two states, RUN and HOLD, plus a 2-bit bubble counter `cnt`.
  - RUN with N≥1: assert `pc_stall`, `ifid_stall` and `idex_flush` this cycle. If N=2, go to HOLD with `cnt`=1; otherwise stay in RUN.
  - HOLD: assert the same three outputs. Decrement `cnt`; when `cnt` reaches 0, return to RUN. Hazard inputs are ignored while in HOLD.
- Redirect: when `id_redirect`=1 and no stall is asserted, assert `ifid_flush`=1 for that cycle only. `id_redirect` is ignored while stalling, because operands are not valid.
- Freeze: `dmem_busy`=1 has highest priority.
  - Outputs: `pc_stall`=`ifid_stall`=`pipe_freeze`=1, and `idex_flush`=`ifid_flush`=0.
  - State and `cnt` do not advance.
  - A pending redirect is not lost: ID is frozen, so it re-presents `id_redirect` after the freeze ends.
- Priority, highest first: reset, freeze, HOLD, RUN hazard, redirect.
- Statistics counters are sampled each cycle from the final outputs and wrap modulo 2^STAT_W. Freeze cycles count toward `stall_cycles`.

## Timing
- All control outputs are combinational from state and inputs, so they are valid in the same cycle. Stage registers sample them at the next posedge.
- While `rst`=1, all control outputs are forced to 0. At the next edge: state=RUN, `cnt`=0, both counters=0.
- Reset asserted during HOLD aborts the sequence. There is no residual stall after reset.
- Stall latency equals N cycles. A load followed immediately by a dependent branch gives exactly 2 stall cycles, then the branch resolves.
- A flush is exactly 1 cycle per redirect.
- `dmem_busy` asserted during HOLD extends HOLD by the freeze length. The bubble count is preserved.

## Structure
- Add to the shared `define.vh`: the state encodings `PCTL_RUN`/`PCTL_HOLD`, plus `REG_ADDR_W`, `STALL_EN`, `FLUSH_EN`, `RST_ACTIVE_H` and `ZERO`.
- There is one natural sub-module, `hazard_detect`: combinational match logic that outputs N (2 bits). The FSM, priority muxing and counters stay in `pipeline_ctrl`.

## Test plan
- Load-use: ID/EX=`lw x5`, ID=`add x6,x5,x1` → one cycle with `pc_stall`=`ifid_stall`=`idex_flush`=1, then all outputs 0 and `stall_cycles`=1.
- Load then dependent branch: ID/EX=`lw x5`, ID=`beq x5,x0` → 2 consecutive stall cycles (RUN→HOLD→RUN) and `stall_cycles`=2. Any hazard change during HOLD is ignored.
- Destination is x0: ID/EX=`lw x0`, ID reads x0 → no stall.
- Redirect: `id_redirect`=1 with no hazard → `ifid_flush`=1 for 1 cycle and `flush_count`=1. `id_redirect`=1 during a stall → `ifid_flush`=0.
- Freeze: `dmem_busy`=1 for 3 cycles during HOLD → `pipe_freeze`=1 for 3 cycles, `idex_flush`=0, HOLD then resumes with its remaining bubble, and `stall_cycles` rises by 5 in total.
- Reset: assert `rst` during HOLD → outputs 0 immediately; after release, state=RUN and both counters=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam logic        STALL_EN     = 1'b1;
  localparam logic        FLUSH_EN     = 1'b1;
  localparam logic        RST_ACTIVE_H = 1'b1;
  localparam logic [REG_ADDR_W-1:0] ZERO = '0;

  // Legacy encodings kept so existing debug tooling decodes the state bit unchanged.
  localparam logic [0:0] PCTL_RUN  = 1'b0;
  localparam logic [0:0] PCTL_HOLD = 1'b1;

  typedef enum logic [0:0] {
    ST_RUN  = PCTL_RUN,
    ST_HOLD = PCTL_HOLD
  } pctl_state_e;

  function automatic logic [1:0] max_bubbles(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush/freeze controls exchanged between the core and pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned STAT_W     = 32
);

  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic                  id_is_branch;
  logic                  id_redirect;
  logic [REG_ADDR_W-1:0] idex_rd_addr;
  logic                  idex_reg_write;
  logic                  idex_mem_read;
  logic [REG_ADDR_W-1:0] exmem_rd_addr;
  logic                  exmem_mem_read;
  logic                  dmem_busy;
  logic                  pc_stall;
  logic                  ifid_stall;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  pipe_freeze;
  logic [STAT_W-1:0]     stall_cycles;
  logic [STAT_W-1:0]     flush_count;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_is_branch, id_redirect,
    output idex_rd_addr, idex_reg_write, idex_mem_read, exmem_rd_addr, exmem_mem_read, dmem_busy,
    input  pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_is_branch, id_redirect,
    input  idex_rd_addr, idex_reg_write, idex_mem_read, exmem_rd_addr, exmem_mem_read, dmem_busy,
    output pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze, stall_cycles, flush_count
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational register-match logic; reports the bubble count N needed by the instruction in ID.
module hazard_detect #(
  parameter int unsigned REG_ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_is_branch,
  input  logic [REG_ADDR_W-1:0] idex_rd_addr,
  input  logic                  idex_reg_write,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
  input  logic                  exmem_mem_read,
  output logic [1:0]            n
);
  import pipeline_ctrl_pkg::*;

  logic ex_match;
  logic mem_match;
  logic [1:0] n_load_use;
  logic [1:0] n_branch_alu;
  logic [1:0] n_branch_mem;

  // x0 is never a real producer, so it can never create a dependency.
  assign ex_match  = (idex_rd_addr != REG_ADDR_W'(ZERO)) &&
                     ((id_rs1_used && (id_rs1_addr == idex_rd_addr)) ||
                      (id_rs2_used && (id_rs2_addr == idex_rd_addr)));
  assign mem_match = (exmem_rd_addr != REG_ADDR_W'(ZERO)) &&
                     ((id_rs1_used && (id_rs1_addr == exmem_rd_addr)) ||
                      (id_rs2_used && (id_rs2_addr == exmem_rd_addr)));

  always_comb begin
    n_load_use   = '0;
    n_branch_alu = '0;
    n_branch_mem = '0;
    if (ex_match && idex_mem_read) begin
      n_load_use = id_is_branch ? 2'd2 : 2'd1;
    end
    if (id_is_branch && ex_match && idex_reg_write && !idex_mem_read) begin
      n_branch_alu = 2'd1;
    end
    if (id_is_branch && mem_match && exmem_mem_read) begin
      n_branch_mem = 2'd1;
    end
    n = max_bubbles(n_load_use, max_bubbles(n_branch_alu, n_branch_mem));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage rv32i core: stall, flush and freeze controls plus
// free-running stall/flush statistics.
module pipeline_ctrl #(
  parameter int unsigned REG_ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W,
  parameter int unsigned STAT_W     = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);
  import pipeline_ctrl_pkg::*;

  pctl_state_e       state;
  pctl_state_e       state_nxt;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nxt;
  logic [1:0]        n;
  logic              pc_stall;
  logic              ifid_stall;
  logic              ifid_flush;
  logic              idex_flush;
  logic              pipe_freeze;
  logic [STAT_W-1:0] stall_cycles;
  logic [STAT_W-1:0] flush_count;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .id_rs1_addr    (bus.id_rs1_addr),
    .id_rs2_addr    (bus.id_rs2_addr),
    .id_rs1_used    (bus.id_rs1_used),
    .id_rs2_used    (bus.id_rs2_used),
    .id_is_branch   (bus.id_is_branch),
    .idex_rd_addr   (bus.idex_rd_addr),
    .idex_reg_write (bus.idex_reg_write),
    .idex_mem_read  (bus.idex_mem_read),
    .exmem_rd_addr  (bus.exmem_rd_addr),
    .exmem_mem_read (bus.exmem_mem_read),
    .n              (n)
  );

  // Priority: reset, freeze, HOLD, RUN hazard, redirect. Freeze leaves state/cnt untouched.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    if (rst != RST_ACTIVE_H) begin
      if (bus.dmem_busy) begin
        pc_stall    = 1'b1;
        ifid_stall  = STALL_EN;
        pipe_freeze = 1'b1;
      end else if (state == ST_HOLD) begin
        pc_stall   = 1'b1;
        ifid_stall = STALL_EN;
        idex_flush = 1'b1;
        if (cnt <= 2'd1) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end else if (n != 2'd0) begin
        pc_stall   = 1'b1;
        ifid_stall = STALL_EN;
        idex_flush = 1'b1;
        if (n > 2'd1) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = n - 2'd1;
        end
      end else if (bus.id_redirect) begin
        ifid_flush = FLUSH_EN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE_H) begin
      state        <= ST_RUN;
      cnt          <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ifid_stall) begin
        stall_cycles <= stall_cycles + STAT_W'(1);
      end
      if (ifid_flush) begin
        flush_count <= flush_count + STAT_W'(1);
      end
    end
  end

  assign bus.pc_stall     = pc_stall;
  assign bus.ifid_stall   = ifid_stall;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.pipe_freeze  = pipe_freeze;
  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_count  = flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expected outputs, a negedge monitor checks.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.REG_ADDR_W(5), .STAT_W(32)) bus ();

  pipeline_ctrl #(.REG_ADDR_W(5), .STAT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          idx;
    logic [4:0]  flags;
    int unsigned sc;
    int unsigned fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vidx   = 0;

  // Flag order: {pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze}
  localparam logic [4:0] O = 5'b00000;
  localparam logic [4:0] B = 5'b11010;
  localparam logic [4:0] F = 5'b00100;
  localparam logic [4:0] Z = 5'b11001;

  task automatic vec(input logic r, input logic busy, input logic redir, input logic br,
                     input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic [4:0] xrd, input logic xrw, input logic xmr,
                     input logic [4:0] mrd, input logic mmr,
                     input logic [4:0] ef, input int unsigned esc, input int unsigned efc);
    exp_t e;
    @(posedge clk);
    #1;
    rst                = r;
    bus.dmem_busy      = busy;
    bus.id_redirect    = redir;
    bus.id_is_branch   = br;
    bus.id_rs1_addr    = rs1;
    bus.id_rs1_used    = u1;
    bus.id_rs2_addr    = rs2;
    bus.id_rs2_used    = u2;
    bus.idex_rd_addr   = xrd;
    bus.idex_reg_write = xrw;
    bus.idex_mem_read  = xmr;
    bus.exmem_rd_addr  = mrd;
    bus.exmem_mem_read = mmr;
    e.idx   = vidx;
    e.flags = ef;
    e.sc    = esc;
    e.fc    = efc;
    exp_q.push_back(e);
    vidx++;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_flush, bus.pipe_freeze};
        checks++;
        if (act !== e.flags) begin
          errors++;
          $display("FAIL flags v%0d: got %b expected %b", e.idx, act, e.flags);
        end
        checks++;
        if (bus.stall_cycles !== 32'(e.sc)) begin
          errors++;
          $display("FAIL stall_cycles v%0d: got %0d expected %0d", e.idx, bus.stall_cycles, e.sc);
        end
        checks++;
        if (bus.flush_count !== 32'(e.fc)) begin
          errors++;
          $display("FAIL flush_count v%0d: got %0d expected %0d", e.idx, bus.flush_count, e.fc);
        end
      end
    end
  end

  initial begin : driver
    bus.dmem_busy = 1'b0; bus.id_redirect = 1'b0; bus.id_is_branch = 1'b0;
    bus.id_rs1_addr = '0; bus.id_rs1_used = 1'b0; bus.id_rs2_addr = '0; bus.id_rs2_used = 1'b0;
    bus.idex_rd_addr = '0; bus.idex_reg_write = 1'b0; bus.idex_mem_read = 1'b0;
    bus.exmem_rd_addr = '0; bus.exmem_mem_read = 1'b0;

    //  rst bsy rdr br  rs1 u1 rs2 u2  xrd xrw xmr  mrd mmr  flags sc fc
    vec(1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  O,  0, 0);  // reset
    vec(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  O,  0, 0);
    vec(0, 0, 0, 0,  5, 1, 1, 1,  5, 1, 1,  0, 0,  B,  0, 0);  // lw x5 ; add x6,x5,x1
    vec(0, 0, 0, 0,  5, 1, 1, 1,  0, 0, 0,  5, 1,  O,  1, 0);  // non-branch ignores EX/MEM load
    vec(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  O,  1, 0);
    vec(0, 0, 0, 0,  0, 1, 0, 1,  0, 1, 1,  0, 0,  O,  1, 0);  // lw x0 ; reads x0
    vec(0, 0, 0, 1,  5, 1, 0, 1,  5, 1, 1,  0, 0,  B,  1, 0);  // lw x5 ; beq x5,x0 -> HOLD
    vec(0, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  B,  2, 0);  // HOLD ignores inputs and redirect
    vec(0, 0, 1, 1,  5, 1, 0, 1,  0, 0, 0,  0, 0,  F,  3, 0);  // branch resolves and redirects
    vec(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  O,  3, 1);
    vec(0, 0, 1, 0,  5, 1, 1, 1,  5, 1, 1,  0, 0,  B,  3, 1);  // redirect during stall dropped
    vec(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  O,  4, 1);
    vec(0, 0, 0, 1,  3, 1, 7, 1,  7, 1, 0,  0, 0,  B,  4, 1);  // branch after ALU on rs2
    vec(0, 0, 0, 1,  9, 1, 0, 0,  0, 0, 0,  9, 1,  B,  5, 1);  // branch after load in MEM
    vec(0, 0, 0, 0,  9, 1, 0, 0,  0, 0, 0,  9, 1,  O,  6, 1);
    vec(0, 0, 0, 0,  5, 0, 0, 0,  5, 1, 1,  0, 0,  O,  6, 1);  // address match, used bit clear
    vec(0, 0, 0, 0,  7, 1, 0, 0,  7, 1, 0,  0, 0,  O,  6, 1);  // ALU result to non-branch
    vec(0, 0, 0, 1,  5, 1, 0, 1,  5, 1, 1,  0, 0,  B,  6, 1);  // enter HOLD
    vec(0, 1, 1, 1,  5, 1, 0, 1,  5, 1, 1,  0, 0,  Z,  7, 1);  // freeze x3 inside HOLD
    vec(0, 1, 1, 1,  5, 1, 0, 1,  5, 1, 1,  0, 0,  Z,  8, 1);
    vec(0, 1, 1, 1,  5, 1, 0, 1,  5, 1, 1,  0, 0,  Z,  9, 1);
    vec(0, 0, 0, 1,  5, 1, 0, 1,  5, 1, 1,  0, 0,  B, 10, 1);  // remaining bubble
    vec(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  O, 11, 1);
    vec(0, 1, 1, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  Z, 11, 1);  // freeze masks redirect
    vec(0, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  F, 12, 1);  // redirect re-presented
    vec(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  O, 12, 2);
    vec(0, 0, 0, 1,  5, 1, 0, 1,  5, 1, 1,  0, 0,  B, 12, 2);  // enter HOLD
    vec(1, 0, 0, 1,  5, 1, 0, 1,  5, 1, 1,  0, 0,  O, 13, 2);  // reset aborts HOLD
    vec(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  O,  0, 0);  // no residual stall
    vec(0, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  F,  0, 0);
    vec(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  O,  0, 1);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
